// File: rtl/button_events.sv
// button_events: turns a debounced button level into single-cycle
// press / release / click / long-press / auto-repeat event pulses.
module button_events #(
  parameter int unsigned CLK_FREQ_KHZ = 100_000,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic release_o,
  output logic click,
  output logic long_press,
  output logic repeat_o,
  output logic held
);

  typedef enum logic [2:0] {
    S_INIT,
    S_LOCKOUT,
    S_IDLE,
    S_PRESSED,
    S_HELD
  } state_t;

  localparam int unsigned REP_M1 =
    (REPEAT_MS == 0) ? 0 : REPEAT_MS - 1;

  localparam logic [23:0] PRESC_LAST = 24'(CLK_FREQ_KHZ - 1);
  localparam logic [15:0] LONG_LAST  = 16'(LONG_MS - 1);
  localparam logic [15:0] REP_LAST   = 16'(REP_M1);
  localparam logic        REP_EN     = (REPEAT_MS != 0);
  localparam logic [15:0] SAT        = 16'hFFFF;

  state_t      state_q, state_d;
  logic        btn_q;
  logic [23:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] rep_q, rep_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic click_q, click_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic held_q, held_d;

  logic rise, fall, ms_tick, timing;

  // Next-state, timer and event decode; thresholds are checked
  // on the tick that would reach them so pulses land on time.
  always_comb begin
    rise    = btn & ~btn_q;
    fall    = ~btn & btn_q;
    ms_tick = (presc_q == PRESC_LAST);
    timing  = (state_q == S_PRESSED) || (state_q == S_HELD);

    state_d   = state_q;
    presc_d   = ms_tick ? 24'd0 : presc_q + 24'd1;
    ms_d      = ms_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (ms_tick && timing && ms_q != SAT)
      ms_d = ms_q + 16'd1;
    if (ms_tick && state_q == S_HELD && rep_q != SAT)
      rep_d = rep_q + 16'd1;

    unique case (state_q)
      S_INIT: begin
        state_d = btn ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (!btn) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          presc_d = 24'd0;
          ms_d    = 16'd0;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (ms_tick && ms_q == LONG_LAST) begin
          state_d = S_HELD;
          long_d  = 1'b1;
          rep_d   = 16'd0;
        end
      end
      S_HELD: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (REP_EN && ms_tick && rep_q == REP_LAST) begin
          repeat_d = 1'b1;
          rep_d    = 16'd0;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    held_d = (state_d == S_PRESSED) || (state_d == S_HELD)
           || release_d;
  end

  // State, timers and registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      btn_q     <= 1'b0;
      presc_q   <= 24'd0;
      ms_q      <= 16'd0;
      rep_q     <= 16'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press      = press_q;
  assign release_o  = release_q;
  assign click      = click_q;
  assign long_press = long_q;
  assign repeat_o   = repeat_q;
  assign held       = held_q;

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: random and directed button traffic checked
// against a hold-duration event model, repeat on and off.
module tb_button_events;

  localparam int K  = 10;
  localparam int L  = 5;
  localparam int R  = 2;
  localparam int LK = L * K;
  localparam int RK = R * K;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  logic [5:0] o_a, o_b;

  int n_chk = 0;
  int n_err = 0;

  // model state
  bit m_active, m_lf, m_prev, m_seen_low;
  int m_cnt;
  bit e_press, e_rel, e_click, e_long, e_rep, e_held;

  always #5 clk = ~clk;

  button_events #(
    .CLK_FREQ_KHZ(K), .LONG_MS(L), .REPEAT_MS(R)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .press(o_a[0]), .release_o(o_a[1]), .click(o_a[2]),
    .long_press(o_a[3]), .repeat_o(o_a[4]), .held(o_a[5])
  );

  button_events #(
    .CLK_FREQ_KHZ(K), .LONG_MS(L), .REPEAT_MS(0)
  ) dut0 (
    .clk(clk), .rst(rst), .btn(btn),
    .press(o_b[0]), .release_o(o_b[1]), .click(o_b[2]),
    .long_press(o_b[3]), .repeat_o(o_b[4]), .held(o_b[5])
  );

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0b exp=%0b",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_lf = 0; m_prev = 0; m_seen_low = 0;
    m_cnt = 0;
    e_press = 0; e_rel = 0; e_click = 0;
    e_long = 0; e_rep = 0; e_held = 0;
  endtask

  // One clock edge of the model, from hold-duration rules.
  task automatic model_edge(input bit b);
    e_press = 0; e_rel = 0; e_click = 0;
    e_long = 0; e_rep = 0;
    if (m_active) begin
      if (!b) begin
        e_rel = 1;
        e_click = !m_lf;
        m_active = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LK) begin
          e_long = 1;
          m_lf = 1;
        end else if (m_lf && ((m_cnt - LK) % RK) == 0) begin
          e_rep = 1;
        end
      end
    end else if (b && !m_prev && m_seen_low) begin
      m_active = 1;
      m_cnt = 0;
      m_lf = 0;
      e_press = 1;
    end
    if (!b) m_seen_low = 1;
    m_prev = b;
    e_held = m_active || e_rel;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".press"},   o_a[0], e_press);
    chk({pfx, ".release"}, o_a[1], e_rel);
    chk({pfx, ".click"},   o_a[2], e_click);
    chk({pfx, ".long"},    o_a[3], e_long);
    chk({pfx, ".repeat"},  o_a[4], e_rep);
    chk({pfx, ".held"},    o_a[5], e_held);
    chk({pfx, ".press0"},  o_b[0], e_press);
    chk({pfx, ".release0"},o_b[1], e_rel);
    chk({pfx, ".click0"},  o_b[2], e_click);
    chk({pfx, ".long0"},   o_b[3], e_long);
    chk({pfx, ".repeat0"}, o_b[4], 1'b0);
    chk({pfx, ".held0"},   o_b[5], e_held);
  endtask

  task automatic step(input bit b, input bit r = 0);
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(b);
    #1;
    check_all(r ? "rst" : "run");
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic async_rst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async");
  endtask

  initial begin
    model_reset();
    // reset state
    step(0, 1);
    step(0, 1);
    hold(0, 5);
    // short press
    hold(1, 20);
    hold(0, 10);
    // long hold with repeats
    hold(1, 100);
    hold(0, 10);
    // threshold boundary
    hold(1, LK);
    hold(0, 10);
    hold(1, LK + 1);
    hold(0, 10);
    // reset with button held
    step(1, 1);
    step(1, 1);
    hold(1, 30);
    hold(0, 5);
    hold(1, 20);
    hold(0, 5);
    // async reset mid-hold
    hold(1, 61);
    async_rst();
    step(1, 1);
    hold(1, 5);
    hold(0, 5);
    // long hold, repeat disabled instance too
    hold(1, 200);
    hold(0, 10);
    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int hi;
      hold(0, $urandom_range(1, 12));
      case ($urandom_range(0, 3))
        0: hi = $urandom_range(1, 40);
        1: hi = LK - 1 + $urandom_range(0, 2);
        2: hi = $urandom_range(60, 140);
        default: hi = LK + RK - 1 + $urandom_range(0, 2);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        hold(1, $urandom_range(1, hi));
        async_rst();
        step(btn, 1);
      end else begin
        hold(1, hi);
      end
    end
    hold(0, 10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
